// File: rtl/bus_decoder.sv
// Single-master to multi-slave address decoder with per-access timeout and
// error response generation (decode miss or slave timeout).
module bus_decoder #(
    parameter int unsigned             SLAVE_CNT  = 4,
    parameter logic [32*SLAVE_CNT-1:0] SLAVE_BASE = {32'h3000_0000, 32'h2000_0000,
                                                     32'h1000_0000, 32'h0000_0000},
    parameter logic [32*SLAVE_CNT-1:0] SLAVE_MASK = {4{32'hF000_0000}},
    parameter int unsigned             TIMEOUT    = 255,
    parameter logic [31:0]             ERR_RDATA  = 32'hDEAD_BEEF
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [31:0]               m_addr,
    input  logic [31:0]               m_wdata,
    output logic [31:0]               m_rdata,
    input  logic                      m_valid,
    input  logic [3:0]                m_wen,
    output logic                      m_ready,
    output logic [32*SLAVE_CNT-1:0]   s_addr,
    output logic [32*SLAVE_CNT-1:0]   s_wdata,
    input  logic [32*SLAVE_CNT-1:0]   s_rdata,
    output logic [SLAVE_CNT-1:0]      s_valid,
    output logic [4*SLAVE_CNT-1:0]    s_wen,
    input  logic [SLAVE_CNT-1:0]      s_ready,
    output logic                      err,
    output logic [31:0]               err_addr,
    output logic [7:0]                err_cnt
);

    localparam int unsigned SW = (SLAVE_CNT > 1) ? $clog2(SLAVE_CNT) : 1;
    localparam int unsigned CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] CNT_LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

    typedef enum logic [1:0] {IDLE, BUSY, ERR, WAITLOW} state_t;

    state_t        state;
    logic [SW-1:0] sel;
    logic [CW-1:0] cnt;

    logic          hit;
    logic [SW-1:0] hit_idx;
    logic          sel_ready;
    logic [31:0]   sel_rdata;
    logic          err_entry;

    assign s_addr  = {SLAVE_CNT{m_addr}};
    assign s_wdata = {SLAVE_CNT{m_wdata}};

    // Ascending scan keeps the first (lowest-index) match on overlapping windows.
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        for (int unsigned i = 0; i < SLAVE_CNT; i++) begin
            if (!hit && ((m_addr & SLAVE_MASK[32*i +: 32]) == SLAVE_BASE[32*i +: 32])) begin
                hit     = 1'b1;
                hit_idx = SW'(i);
            end
        end
    end

    assign sel_ready = s_ready[sel];
    assign sel_rdata = s_rdata[32*sel +: 32];

    always_comb begin
        err_entry = 1'b0;
        if (state == IDLE && m_valid && !hit)
            err_entry = 1'b1;
        else if (state == BUSY && m_valid && !sel_ready && TIMEOUT != 0 && cnt == CNT_LAST)
            err_entry = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            sel      <= '0;
            cnt      <= '0;
            err      <= 1'b0;
            err_addr <= '0;
            err_cnt  <= '0;
        end else begin
            err <= 1'b0;
            if (err_entry) begin
                err      <= 1'b1;
                err_addr <= m_addr;
                if (err_cnt != 8'hFF)
                    err_cnt <= err_cnt + 8'd1;
            end
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (m_valid) begin
                        sel   <= hit_idx;
                        state <= hit ? BUSY : ERR;
                    end
                end
                BUSY: begin
                    if (!m_valid)
                        state <= IDLE;
                    else if (sel_ready)
                        cnt <= '0;
                    else if (err_entry)
                        state <= ERR;
                    else if (TIMEOUT != 0)
                        cnt <= cnt + CW'(1);
                end
                ERR:     state <= WAITLOW;
                WAITLOW: if (!m_valid) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        s_valid = '0;
        s_wen   = '0;
        m_ready = 1'b0;
        m_rdata = '0;
        case (state)
            BUSY: begin
                s_valid[sel]        = m_valid;
                s_wen[4*sel +: 4]   = m_wen;
                m_ready             = sel_ready;
                m_rdata             = sel_rdata;
            end
            ERR, WAITLOW: begin
                m_ready = 1'b1;
                m_rdata = ERR_RDATA;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_bus_decoder.sv
// Scoreboard bench for bus_decoder: directed accesses push expected responses,
// a negedge monitor pops and compares on each master acknowledge.
module tb_bus_decoder;

    logic         clk;
    logic         reset;
    logic [31:0]  m_addr;
    logic [31:0]  m_wdata;
    logic [31:0]  m_rdata;
    logic         m_valid;
    logic [3:0]   m_wen;
    logic         m_ready;
    logic [127:0] s_addr;
    logic [127:0] s_wdata;
    logic [127:0] s_rdata;
    logic [3:0]   s_valid;
    logic [15:0]  s_wen;
    logic [3:0]   s_ready;
    logic         err;
    logic [31:0]  err_addr;
    logic [7:0]   err_cnt;

    bus_decoder #(
        .SLAVE_CNT (4),
        .SLAVE_MASK({32'hFFFF_FFFF, {3{32'hF000_0000}}}),
        .TIMEOUT   (4)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .m_addr  (m_addr),
        .m_wdata (m_wdata),
        .m_rdata (m_rdata),
        .m_valid (m_valid),
        .m_wen   (m_wen),
        .m_ready (m_ready),
        .s_addr  (s_addr),
        .s_wdata (s_wdata),
        .s_rdata (s_rdata),
        .s_valid (s_valid),
        .s_wen   (s_wen),
        .s_ready (s_ready),
        .err     (err),
        .err_addr(err_addr),
        .err_cnt (err_cnt)
    );

    typedef struct {
        logic [31:0] rdata;
        logic [3:0]  sv;
        logic [15:0] swen;
        logic        errp;
        logic [31:0] eaddr;
        logic [7:0]  ecnt;
        logic [31:0] addr;
        logic [31:0] wdata;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          fails  = 0;
    logic [7:0]  err_cnt_m  = 8'd0;
    logic [31:0] err_addr_m = 32'd0;
    logic        taken = 1'b0;
    int          scnt[4] = '{0, 0, 0, 0};
    int          lat[4]  = '{1, 1000, 2, 1};

    assign s_rdata = {32'h3333_3333, 32'h1234_5678, 32'h1111_1111, 32'h0000_00A0};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push_ok(input logic [31:0] rdata, input logic [3:0] sv, input logic [15:0] swen,
                           input logic [31:0] addr, input logic [31:0] wdata);
        exp_t e;
        e = '{rdata, sv, swen, 1'b0, err_addr_m, err_cnt_m, addr, wdata};
        sb.push_back(e);
    endtask

    task automatic push_err(input logic [31:0] addr, input logic [31:0] wdata);
        exp_t e;
        if (err_cnt_m != 8'd255) err_cnt_m = err_cnt_m + 8'd1;
        err_addr_m = addr;
        e = '{32'hDEAD_BEEF, 4'b0000, 16'h0000, 1'b1, err_addr_m, err_cnt_m, addr, wdata};
        sb.push_back(e);
    endtask

    // Master: request in IDLE, hold until acknowledged, then drop m_valid.
    task automatic xfer(input logic [31:0] addr, input logic [3:0] wen, input logic [31:0] wdata,
                        input logic use_alt, input logic [31:0] alt, output int nsv);
        int   k;
        logic done;
        @(posedge clk);
        #1;
        m_addr  = addr;
        m_wen   = wen;
        m_wdata = wdata;
        m_valid = 1'b1;
        nsv  = 0;
        done = 1'b0;
        k    = 0;
        while (!done && k < 50) begin
            @(negedge clk);
            if (|s_valid) nsv++;
            if (m_ready) done = 1'b1;
            else if (use_alt && k == 1) begin
                #1 m_addr = alt;
            end
            k++;
        end
        chk("xfer_ack", {31'd0, done}, 32'd1);
        @(posedge clk);
        #1;
        m_valid = 1'b0;
        m_wen   = 4'd0;
    endtask

    // Slave model: ready after lat[i] consecutive cycles of s_valid[i].
    initial begin
        s_ready = '0;
        forever begin
            @(posedge clk);
            #2;
            for (int i = 0; i < 4; i++) begin
                if (s_valid[i]) begin
                    scnt[i]++;
                    s_ready[i] = (scnt[i] >= lat[i]);
                end else begin
                    scnt[i]    = 0;
                    s_ready[i] = 1'b0;
                end
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (!m_valid) taken = 1'b0;
        else if (m_ready && !taken) begin
            taken = 1'b1;
            if (sb.size() == 0) begin
                chk("sb_unexpected_ack", {31'd0, m_ready}, 32'd0);
            end else begin
                e = sb.pop_front();
                chk("m_rdata", m_rdata, e.rdata);
                chk("s_valid", {28'd0, s_valid}, {28'd0, e.sv});
                chk("s_wen", {16'd0, s_wen}, {16'd0, e.swen});
                chk("err", {31'd0, err}, {31'd0, e.errp});
                chk("err_addr", err_addr, e.eaddr);
                chk("err_cnt", {24'd0, err_cnt}, {24'd0, e.ecnt});
                chk("s_addr3", s_addr[127:96], e.addr);
                chk("s_wdata2", s_wdata[95:64], e.wdata);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        int nsv;
        reset   = 1'b1;
        m_valid = 1'b0;
        m_addr  = '0;
        m_wdata = '0;
        m_wen   = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_m_ready", {31'd0, m_ready}, 32'd0);
        chk("rst_m_rdata", m_rdata, 32'd0);
        chk("rst_s_valid", {28'd0, s_valid}, 32'd0);
        chk("rst_err_cnt", {24'd0, err_cnt}, 32'd0);
        chk("rst_err_addr", err_addr, 32'd0);
        @(posedge clk);
        #1 reset = 1'b0;

        push_ok(32'h1234_5678, 4'b0100, 16'h0000, 32'h2000_0010, 32'h0);
        xfer(32'h2000_0010, 4'b0000, 32'h0, 1'b0, 32'h0, nsv);
        chk("read2_sv_cycles", nsv, 32'd2);
        @(posedge clk);
        @(negedge clk);
        chk("idle_m_ready", {31'd0, m_ready}, 32'd0);
        chk("idle_m_rdata", m_rdata, 32'd0);

        push_ok(32'h0000_00A0, 4'b0001, 16'h0001, 32'h0000_0004, 32'hAABB_CCDD);
        xfer(32'h0000_0004, 4'b0001, 32'hAABB_CCDD, 1'b0, 32'h0, nsv);

        push_ok(32'h3333_3333, 4'b1000, 16'hC000, 32'h3000_0000, 32'h0102_0304);
        xfer(32'h3000_0000, 4'b1100, 32'h0102_0304, 1'b0, 32'h0, nsv);

        push_err(32'h3000_0004, 32'h0);
        xfer(32'h3000_0004, 4'b0000, 32'h0, 1'b0, 32'h0, nsv);

        push_err(32'h3000_0008, 32'hFFFF_0000);
        xfer(32'h3000_0008, 4'b1111, 32'hFFFF_0000, 1'b0, 32'h0, nsv);

        push_err(32'h1000_0020, 32'h0);
        xfer(32'h1000_0020, 4'b0000, 32'h0, 1'b0, 32'h0, nsv);
        chk("timeout_sv_cycles", nsv, 32'd4);

        push_ok(32'h0000_00A0, 4'b0001, 16'h0000, 32'h0000_0010, 32'h0);
        xfer(32'h0000_0010, 4'b0000, 32'h0, 1'b0, 32'h0, nsv);

        // m_addr moves to slave 0's window mid-access; selection must stay on slave 2
        push_ok(32'h1234_5678, 4'b0100, 16'h0000, 32'h0000_0008, 32'h0);
        xfer(32'h2000_0000, 4'b0000, 32'h0, 1'b1, 32'h0000_0008, nsv);

        @(posedge clk);
        #1;
        m_addr  = 32'h1000_0000;
        m_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("abort_busy_sv", {28'd0, s_valid}, 32'h2);
        @(posedge clk);
        #1 m_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("abort_m_ready", {31'd0, m_ready}, 32'd0);
        chk("abort_s_valid", {28'd0, s_valid}, 32'd0);
        chk("abort_err_cnt", {24'd0, err_cnt}, 32'd3);
        chk("abort_err", {31'd0, err}, 32'd0);
        @(negedge clk);
        chk("abort_err_late", {31'd0, err}, 32'd0);

        push_err(32'h5000_0000, 32'h0);
        @(posedge clk);
        #1;
        m_addr  = 32'h5000_0000;
        m_valid = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        chk("waitlow_m_ready", {31'd0, m_ready}, 32'd1);
        chk("waitlow_m_rdata", m_rdata, 32'hDEAD_BEEF);
        chk("waitlow_err_low", {31'd0, err}, 32'd0);
        @(posedge clk);
        #1;
        reset   = 1'b0;
        m_valid = 1'b0;
        @(negedge clk);
        chk("rstw_m_ready", {31'd0, m_ready}, 32'd0);
        chk("rstw_err_cnt", {24'd0, err_cnt}, 32'd0);
        chk("rstw_err_addr", err_addr, 32'd0);
        chk("rstw_err", {31'd0, err}, 32'd0);
        chk("rstw_m_rdata", m_rdata, 32'd0);
        err_cnt_m  = 8'd0;
        err_addr_m = 32'd0;

        for (int i = 0; i < 260; i++) begin
            push_err(32'h4000_0000, 32'(i));
            xfer(32'h4000_0000, 4'b0000, 32'(i), 1'b0, 32'h0, nsv);
        end
        chk("sat_err_cnt", {24'd0, err_cnt}, 32'd255);

        repeat (3) @(posedge clk);
        chk("sb_empty", sb.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule

// File: doc/bus_decoder.md
BUS_DECODER -- requirements
Module: bus_decoder

Interface
REQ-001 SHALL have parameter SLAVE_CNT, default 4: number of slave ports, 1..16.
REQ-002 SHALL have parameter SLAVE_BASE, default {32'h3000_0000, 32'h2000_0000, 32'h1000_0000, 32'h0000_0000}: packed 32*SLAVE_CNT base addresses, slice i = slave i.
REQ-003 SHALL have parameter SLAVE_MASK, default {4{32'hF000_0000}}: packed 32*SLAVE_CNT decode masks.
REQ-004 SHALL have parameter TIMEOUT, default 255: cycles to wait for s_ready before erroring; 0 disables timeout.
REQ-005 SHALL have parameter ERR_RDATA, default 32'hDEADBEEF: rdata returned on error.
REQ-006 clk  in  1  system clock; all state updates on rising edge.
REQ-007 reset  in  1  synchronous, active-high reset.
REQ-008 m_addr  in  32  master address.
REQ-009 m_wdata  in  32  master write data.
REQ-010 m_rdata  out  32  read data to master.
REQ-011 m_valid  in  1  master request.
REQ-012 m_wen  in  4  byte write enables; 0 = read.
REQ-013 m_ready  out  1  transfer acknowledge to master.
REQ-014 s_addr  out  32*SLAVE_CNT  address to each slave, packed by index.
REQ-015 s_wdata  out  32*SLAVE_CNT  write data to each slave.
REQ-016 s_rdata  in  32*SLAVE_CNT  read data from each slave.
REQ-017 s_valid  out  SLAVE_CNT  per-slave request.
REQ-018 s_wen  out  4*SLAVE_CNT  per-slave byte enables.
REQ-019 s_ready  in  SLAVE_CNT  per-slave acknowledge.
REQ-020 err  out  1  one-cycle pulse on each decode or timeout error.
REQ-021 err_addr  out  32  m_addr of most recent error.
REQ-022 err_cnt  out  8  saturating error count.

Function
REQ-023 Slave i SHALL match when (m_addr & MASK_i) == BASE_i; on multiple matches, lowest index wins.
REQ-024 s_addr and s_wdata slices SHALL all carry m_addr/m_wdata unconditionally; only s_valid/s_wen are gated.
REQ-025 FSM states SHALL be IDLE, BUSY, ERR, WAITLOW.
REQ-026 IDLE: s_valid=0, s_wen=0, m_ready=0; on m_valid=1, latch decoded index into sel and go BUSY (match) or ERR (no match); counter cleared.
REQ-027 BUSY: s_valid[sel]=m_valid, s_wen[sel]=m_wen, all other slaves 0; m_ready=s_ready[sel] and m_rdata=s_rdata[sel], combinational pass-through.
REQ-028 BUSY: counter increments each cycle with s_ready[sel]=0; reset to 0 when s_ready[sel]=1.
REQ-029 BUSY -> IDLE when m_valid=0 (normal completion or master abort); abort before ready needs no slave-side action.
REQ-030 BUSY -> ERR when TIMEOUT!=0 and counter reaches TIMEOUT with s_ready[sel] still 0; s_valid[sel] drops in ERR.
REQ-031 ERR: all s_valid/s_wen 0; m_ready=1, m_rdata=ERR_RDATA; writes discarded; -> WAITLOW next cycle.
REQ-032 WAITLOW: m_ready=1, m_rdata=ERR_RDATA until m_valid=0, then IDLE.
REQ-033 On entry to ERR: err=1 for exactly one cycle, err_addr<=m_addr, err_cnt<=err_cnt+1, saturating at 255.
REQ-034 Decode SHALL be evaluated only in IDLE; m_addr change during BUSY SHALL NOT change sel.
REQ-035 Minimum access: request cycle, ack cycle, one m_valid-low cycle; back-to-back requests without m_valid low SHALL NOT occur.
REQ-036 m_rdata SHALL be 0 in IDLE.
REQ-037 Counter width SHALL be $clog2(TIMEOUT+1), minimum 1 bit.

Reset
REQ-038 reset SHALL force state IDLE, sel=0, counter=0, err=0, err_addr=0, err_cnt=0; hence s_valid=0, s_wen=0, m_ready=0, m_rdata=0 from the next cycle.
REQ-039 reset during BUSY/ERR/WAITLOW SHALL abort the transaction without an err pulse; reset takes precedence over all transitions.

Verification
REQ-040 Read slave 2: m_addr=0x2000_0010, m_valid=1, s_ready[2]=1 with s_rdata[2]=0x1234_5678 two cycles later -> s_valid=4'b0100, m_ready=1, m_rdata=0x1234_5678; IDLE one cycle after m_valid=0.
REQ-041 Write byte: m_wen=4'b0001 to 0x0000_0004 -> s_wen[3:0]=4'b0001, other s_wen 0, s_valid=4'b0001.
REQ-042 Unmapped: SLAVE_MASK slice 3 = 32'hFFFF_FFFF, BASE 3 = 0x3000_0000, m_addr=0x3000_0004 -> no s_valid; m_ready=1, m_rdata=0xDEADBEEF, err pulse, err_addr=0x3000_0004, err_cnt=1.
REQ-043 Timeout: TIMEOUT=4, slave 1 never ready -> s_valid[1] high 4 cycles, then ERR with m_ready=1, m_rdata=0xDEADBEEF, err_cnt increments.
REQ-044 Abort/reset: m_valid drops in BUSY before ready -> IDLE, no err; reset asserted in WAITLOW -> m_ready=0, err_cnt=0 next cycle.
REQ-045 Saturation: 260 consecutive unmapped accesses -> err_cnt=255.
